// File: rtl/ahb_fir_slave_fifo.sv
// ahb_fir_slave_fifo
// AHB-Lite slave that sits in front of the FIR filter. It holds the coefficient
// bank and a sample FIFO. It hands queued samples to the filter one at a time
// and sequences coefficient reloads with the coefficient loader.
//
// Ports
//   clk, n_rst            clock; synchronous active-low reset
//   hsel .. hwdata        AHB-Lite slave inputs (address phase and data phase)
//   hrdata, hresp         AHB-Lite data-phase read data and error response
//   fir_out               filter result, returned on RESULT reads
//   modwait, err          filter/loader busy flag and filter error flag
//   coefficient_num       coefficient index requested by the loader
//   sample_data           FIFO head that was last issued to the filter
//   data_ready            one-cycle strobe marking a newly issued sample
//   fir_coefficient       coefficient selected by coefficient_num
//   new_coefficient_set   high while a coefficient reload is running
//
// Register map (halfword addresses)
//   0 STATUS, 2 RESULT, 4 SAMPLE, 6+2i COEFF[i], 6+2*NUM_COEFF COEF_SET
module ahb_fir_slave_fifo #(
    parameter int NUM_COEFF  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         hsel,
    input  logic [1:0]                   htrans,
    input  logic [ADDR_WIDTH-1:0]        haddr,
    input  logic                         hsize,
    input  logic                         hwrite,
    input  logic [15:0]                  hwdata,
    output logic [15:0]                  hrdata,
    output logic                         hresp,
    input  logic [15:0]                  fir_out,
    input  logic                         modwait,
    input  logic                         err,
    input  logic [$clog2(NUM_COEFF)-1:0] coefficient_num,
    output logic [15:0]                  sample_data,
    output logic                         data_ready,
    output logic [15:0]                  fir_coefficient,
    output logic                         new_coefficient_set
);
    localparam int CW = $clog2(NUM_COEFF);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH-2:0] idx_t;
    typedef logic [PW:0]           cnt_t;

    localparam addr_t A_COEF_SET = addr_t'(6 + 2 * NUM_COEFF);
    localparam idx_t  IDX_STATUS = idx_t'(0);
    localparam idx_t  IDX_RESULT = idx_t'(1);
    localparam idx_t  IDX_SAMPLE = idx_t'(2);
    localparam idx_t  IDX_COEF0  = idx_t'(3);
    localparam idx_t  IDX_CSET   = idx_t'(3 + NUM_COEFF);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} s_state_t;
    typedef enum logic [1:0] {C_IDLE, C_PEND, C_LOAD, C_LAST} c_state_t;

    // Data-phase copy of the address-phase controls
    logic                  r_dp_valid;
    addr_t                 r_dp_addr;
    logic                  r_dp_size;
    logic                  r_dp_write;

    logic [15:0]           r_coeff [NUM_COEFF];
    logic [15:0]           r_fifo  [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    cnt_t                  r_count;
    logic [15:0]           r_last_sample;
    logic [15:0]           r_sample_data;
    logic                  r_data_ready;
    logic                  r_coef_set;
    logic                  r_new_coef_set;
    s_state_t              r_s_state;
    c_state_t              r_c_state;

    idx_t                  w_idx;
    logic                  w_is_status, w_is_result, w_is_sample, w_is_cset, w_is_coeff;
    logic                  w_err, w_wr_ok, w_rd_ok;
    logic                  w_empty, w_full, w_push, w_pop, w_busy, w_cset_start;
    logic [7:0]            w_wbyte;
    logic [15:0]           w_push_val, w_rdata, w_fir_coef;
    logic [NUM_COEFF-1:0]  w_coef_we;
    logic                  w_unused;

    assign w_unused = htrans[0];

    function automatic logic [15:0] f_merge(input logic [15:0] old_val, input logic [15:0] wdata,
                                            input logic size, input logic odd);
        if (size)     return wdata;
        else if (odd) return {wdata[15:8], old_val[7:0]};
        else          return {old_val[15:8], wdata[7:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_dp_valid <= 1'b0;
            r_dp_addr  <= '0;
            r_dp_size  <= 1'b0;
            r_dp_write <= 1'b0;
        end else begin
            r_dp_valid <= hsel & htrans[1];
            r_dp_addr  <= haddr;
            r_dp_size  <= hsize;
            r_dp_write <= hwrite;
        end
    end

    // Decode happens in the data phase, off the registered address
    assign w_idx       = r_dp_addr[ADDR_WIDTH-1:1];
    assign w_is_status = (w_idx == IDX_STATUS);
    assign w_is_result = (w_idx == IDX_RESULT);
    assign w_is_sample = (w_idx == IDX_SAMPLE);
    assign w_is_cset   = (w_idx == IDX_CSET);
    assign w_is_coeff  = (w_idx >= IDX_COEF0) && (w_idx < IDX_CSET);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == cnt_t'(FIFO_DEPTH));
    // Samples leave the FIFO only when the filter is idle and no reload is pending
    assign w_pop   = (r_s_state == S_IDLE) && !w_empty && !modwait && (r_c_state == C_IDLE);
    assign w_busy  = modwait | (r_c_state != C_IDLE) | !w_empty;

    assign w_err = r_dp_valid & ((r_dp_addr > A_COEF_SET)
                 | (r_dp_size & r_dp_addr[0])
                 | (r_dp_write & (w_is_status | w_is_result))
                 | (r_dp_write & w_is_sample & w_full & !w_pop)
                 | (r_dp_write & w_is_coeff & (r_c_state != C_IDLE)));
    assign w_wr_ok = r_dp_valid &  r_dp_write & !w_err;
    assign w_rd_ok = r_dp_valid & !r_dp_write & !w_err;

    assign w_wbyte    = r_dp_addr[0] ? hwdata[15:8] : hwdata[7:0];
    assign w_push_val = r_dp_size ? hwdata : (r_dp_addr[0] ? {w_wbyte, 8'h00} : {8'h00, w_wbyte});
    assign w_push     = w_wr_ok & w_is_sample;
    assign w_cset_start = w_wr_ok & w_is_cset & w_wbyte[0] & (r_c_state == C_IDLE);

    generate
        for (genvar gi = 0; gi < NUM_COEFF; gi++) begin : g_coef_we
            assign w_coef_we[gi] = w_wr_ok && (w_idx == idx_t'(3 + gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_COEFF; i++) r_coeff[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_COEFF; i++)
                if (w_coef_we[i])
                    r_coeff[i] <= f_merge(r_coeff[i], hwdata, r_dp_size, r_dp_addr[0]);
        end
    end

    // FIFO storage is not cleared; emptiness is tracked by the count alone
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_push_val;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_last_sample <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr      <= r_wr_ptr + 1'b1;
                r_last_sample <= w_push_val;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_s_state     <= S_IDLE;
            r_sample_data <= '0;
            r_data_ready  <= 1'b0;
        end else begin
            r_data_ready <= 1'b0;
            case (r_s_state)
                S_IDLE:  if (w_pop) begin
                             r_s_state     <= S_ISSUE;
                             r_sample_data <= r_fifo[r_rd_ptr];
                             r_data_ready  <= 1'b1;
                         end
                S_ISSUE: r_s_state <= S_BUSY;
                S_BUSY:  if (modwait)  r_s_state <= S_DONE;
                S_DONE:  if (!modwait) r_s_state <= S_IDLE;
                default: r_s_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_c_state      <= C_IDLE;
            r_coef_set     <= 1'b0;
            r_new_coef_set <= 1'b0;
        end else begin
            case (r_c_state)
                C_IDLE:  if (w_cset_start) begin
                             r_c_state  <= C_PEND;
                             r_coef_set <= 1'b1;
                         end
                C_PEND:  if (r_s_state == S_IDLE) begin
                             r_c_state      <= C_LOAD;
                             r_new_coef_set <= 1'b1;
                         end
                C_LOAD:  if (coefficient_num == CW'(NUM_COEFF - 1) && modwait)
                             r_c_state <= C_LAST;
                C_LAST:  if (!modwait) begin
                             r_c_state      <= C_IDLE;
                             r_new_coef_set <= 1'b0;
                             r_coef_set     <= 1'b0;
                         end
                default: r_c_state <= C_IDLE;
            endcase
        end
    end

    // Reads see registers already updated by the previous data phase,
    // which gives write-then-read forwarding without a bypass path
    always_comb begin
        w_rdata = '0;
        if (w_is_status)      w_rdata = {5'b0, w_empty, w_full, err, 7'b0, w_busy};
        else if (w_is_result) w_rdata = fir_out;
        else if (w_is_sample) w_rdata = r_last_sample;
        else if (w_is_cset)   w_rdata = {15'b0, r_coef_set};
        for (int i = 0; i < NUM_COEFF; i++)
            if (w_idx == idx_t'(3 + i)) w_rdata = r_coeff[i];
    end

    always_comb begin
        w_fir_coef = '0;
        for (int i = 0; i < NUM_COEFF; i++)
            if (coefficient_num == CW'(i)) w_fir_coef = r_coeff[i];
    end

    assign hrdata              = w_rd_ok ? w_rdata : 16'h0000;
    assign hresp               = w_err;
    assign sample_data         = r_sample_data;
    assign data_ready          = r_data_ready;
    assign fir_coefficient     = w_fir_coef;
    assign new_coefficient_set = r_new_coef_set;
endmodule

// File: tb/tb_ahb_fir_slave_fifo.sv
// Directed bench for ahb_fir_slave_fifo with NUM_COEFF=4, FIFO_DEPTH=4, ADDR_WIDTH=5
// (COEF_SET at address 14). Inputs change away from the rising edge and outputs
// are sampled on the falling edge.
module tb_ahb_fir_slave_fifo;
    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        n_rst, hsel, hsize, hwrite, hresp, modwait, err;
    logic [1:0]  htrans, coefficient_num;
    logic [AW-1:0] haddr;
    logic [15:0] hwdata, hrdata, fir_out, sample_data, fir_coefficient;
    logic        data_ready, new_coefficient_set;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] rd;
    logic        rs;
    logic        seen;
    int          lat;

    ahb_fir_slave_fifo #(.NUM_COEFF(4), .FIFO_DEPTH(4), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .n_rst(n_rst), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp),
        .fir_out(fir_out), .modwait(modwait), .err(err), .coefficient_num(coefficient_num),
        .sample_data(sample_data), .data_ready(data_ready), .fir_coefficient(fir_coefficient),
        .new_coefficient_set(new_coefficient_set)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ahb_write(input logic [AW-1:0] a, input logic sz, input logic [15:0] d,
                             output logic rsp);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        @(negedge clk);
        rsp = hresp;
        @(posedge clk); #1;
    endtask

    task automatic ahb_read(input logic [AW-1:0] a, input logic sz,
                            output logic [15:0] d, output logic rsp);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        d = hrdata; rsp = hresp;
        @(posedge clk); #1;
    endtask

    // lat counts falling edges after the call; -1 if no pulse within max_cyc
    task automatic wait_ready(input int max_cyc, output int lat_o);
        lat_o = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (data_ready === 1'b1) begin
                lat_o = i;
                break;
            end
        end
        check("ready_seen", {15'b0, lat_o >= 0}, 16'h0001);
    endtask

    // Walk the sample FSM ISSUE -> BUSY -> DONE -> IDLE via a modwait pulse
    task automatic finish_sample();
        modwait = 1'b1;
        repeat (2) @(posedge clk);
        #1 modwait = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        n_rst = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = '0; hsize = 1'b1; hwrite = 1'b0;
        hwdata = 16'hFFFF; fir_out = 16'hFFFF; modwait = 1'b1; err = 1'b1; coefficient_num = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hrdata", hrdata, 16'h0000);
        check("rst_hresp", {15'b0, hresp}, 16'h0000);
        check("rst_sample_data", sample_data, 16'h0000);
        check("rst_data_ready", {15'b0, data_ready}, 16'h0000);
        check("rst_fir_coef", fir_coefficient, 16'h0000);
        check("rst_new_coef_set", {15'b0, new_coefficient_set}, 16'h0000);
        n_rst = 1'b1; hsel = 1'b0; htrans = 2'b00; modwait = 1'b0; err = 1'b0;
        fir_out = 16'h0000; hwdata = 16'h0000;
        @(posedge clk); #1;
        ahb_read(5'd0, 1'b1, rd, rs);
        check("rst_status", rd, 16'h0400);

        // ---------------- sample issue ----------------
        ahb_write(5'd4, 1'b1, 16'h1000, rs);
        check("s1_hresp", {15'b0, rs}, 16'h0000);
        wait_ready(10, lat);
        check("s1_latency", 16'(lat + 1), 16'd2);
        check("s1_data", sample_data, 16'h1000);
        @(negedge clk);
        check("s1_pulse_width", {15'b0, data_ready}, 16'h0000);
        modwait = 1'b1;
        ahb_write(5'd4, 1'b1, 16'h2000, rs);
        ahb_write(5'd4, 1'b1, 16'h3000, rs);
        ahb_read(5'd0, 1'b1, rd, rs);
        check("s_status_busy", rd, 16'h0001);
        ahb_read(5'd4, 1'b1, rd, rs);
        check("s_last_pushed", rd, 16'h3000);
        check("s_data_held", sample_data, 16'h1000);
        modwait = 1'b0;
        wait_ready(10, lat);
        check("s2_data", sample_data, 16'h2000);
        finish_sample();
        wait_ready(10, lat);
        check("s3_data", sample_data, 16'h3000);
        finish_sample();

        // ---------------- coefficient reload ----------------
        ahb_write(5'd12, 1'b1, 16'h8000, rs);
        check("c_coef3_wr", {15'b0, rs}, 16'h0000);
        ahb_write(5'd14, 1'b1, 16'h0001, rs);
        check("c_cset_wr", {15'b0, rs}, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (new_coefficient_set === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("c_ncs_rise", {15'b0, seen}, 16'h0001);
        ahb_read(5'd14, 1'b1, rd, rs);
        check("c_cset_busy", rd, 16'h0001);
        coefficient_num = 2'd3; #1;
        check("c_fircoef3", fir_coefficient, 16'h8000);
        coefficient_num = 2'd1; #1;
        check("c_fircoef1", fir_coefficient, 16'h0000);
        ahb_write(5'd12, 1'b1, 16'h1111, rs);
        check("c_coef_wr_busy", {15'b0, rs}, 16'h0001);
        ahb_write(5'd4, 1'b1, 16'h5555, rs);
        check("c_sample_queue", {15'b0, rs}, 16'h0000);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | data_ready;
        end
        check("c_no_issue", {15'b0, seen}, 16'h0000);
        coefficient_num = 2'd3; modwait = 1'b1;
        @(negedge clk);
        check("c_ncs_last", {15'b0, new_coefficient_set}, 16'h0001);
        modwait = 1'b0;
        @(negedge clk);
        check("c_ncs_fall", {15'b0, new_coefficient_set}, 16'h0000);
        wait_ready(10, lat);
        check("c_queued_data", sample_data, 16'h5555);
        finish_sample();
        ahb_read(5'd14, 1'b1, rd, rs);
        check("c_cset_done", rd, 16'h0000);
        ahb_read(5'd12, 1'b1, rd, rs);
        check("c_coef3_kept", rd, 16'h8000);

        // ---------------- FIFO full ----------------
        modwait = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ahb_write(5'd4, 1'b1, 16'hA000 + 16'(k), rs);
            check("f_push", {15'b0, rs}, 16'h0000);
        end
        ahb_write(5'd4, 1'b1, 16'hDEAD, rs);
        check("f_overflow_hresp", {15'b0, rs}, 16'h0001);
        ahb_read(5'd0, 1'b1, rd, rs);
        check("f_status_full", rd, 16'h0201);
        ahb_read(5'd4, 1'b1, rd, rs);
        check("f_last_kept", rd, 16'hA003);
        modwait = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(10, lat);
            check("f_drain", sample_data, 16'hA000 + 16'(k));
            finish_sample();
        end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | data_ready;
        end
        check("f_dropped_not_issued", {15'b0, seen}, 16'h0000);
        ahb_read(5'd0, 1'b1, rd, rs);
        check("f_status_empty", rd, 16'h0400);

        // ---------------- byte writes + forwarding ----------------
        hsel = 1'b1; htrans = 2'b10; haddr = 5'd7; hsize = 1'b0; hwrite = 1'b1;
        @(posedge clk); #1;
        hwdata = 16'h3434; haddr = 5'd6;
        @(posedge clk); #1;
        hwdata = 16'h1212; haddr = 5'd6; hsize = 1'b1; hwrite = 1'b0;
        @(negedge clk);
        check("b_wr_hresp", {15'b0, hresp}, 16'h0000);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("b_forward", hrdata, 16'h3412);
        @(posedge clk); #1;

        // ---------------- error responses ----------------
        fir_out = 16'h1234;
        ahb_write(5'd2, 1'b1, 16'hAAAA, rs);
        check("e_result_wr", {15'b0, rs}, 16'h0001);
        ahb_read(5'd2, 1'b1, rd, rs);
        check("e_result_rd", rd, 16'h1234);
        ahb_write(5'd5, 1'b1, 16'hBBBB, rs);
        check("e_misaligned", {15'b0, rs}, 16'h0001);
        ahb_read(5'd4, 1'b1, rd, rs);
        check("e_sample_kept", rd, 16'hA003);
        ahb_write(5'd16, 1'b1, 16'h0001, rs);
        check("e_out_of_range", {15'b0, rs}, 16'h0001);
        ahb_read(5'd16, 1'b1, rd, rs);
        check("e_oor_rd_hresp", {15'b0, rs}, 16'h0001);
        check("e_oor_rd_data", rd, 16'h0000);
        ahb_read(5'd14, 1'b1, rd, rs);
        check("e_cset_kept", rd, 16'h0000);
        err = 1'b1;
        ahb_read(5'd0, 1'b1, rd, rs);
        check("e_status_err", rd, 16'h0500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
